// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the fetch stage.
//   RESET_PC      byte address of the first fetch and base of the imem index
//   INSTR_EBREAK  encoding of ebreak, which halts fetch until a redirect
//   fetch_state_e fetch state machine encoding (FS_RUN, FS_HALT)
//   fetch_entry   one fetch-buffer slot: byte PC plus instruction word
package rv32i_pkg;

    localparam logic [31:0] RESET_PC     = 32'h0040_0000;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry;

    // Clear the byte offset so a target always lands on a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf2.sv
// Two-entry FIFO of fetch_entry between the fetch PC and decode.
//   clk, rst     clock and synchronous active-high reset
//   push_i       write push_data_i at the tail (ignored when full without pop)
//   pop_i        drop the head (ignored when empty)
//   flush_i      empty the FIFO; wins over push and pop
//   push_data_i  entry to write
//   head_o       registered head slot (holds stale data when empty)
//   count_o      number of valid entries, 0..2
module fetch_buf2
    import rv32i_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic       flush_i,
    input  fetch_entry push_data_i,
    output fetch_entry head_o,
    output logic [1:0] count_o
);

    fetch_entry slot0_q, slot0_d;
    fetch_entry slot1_q, slot1_d;
    logic [1:0] count_q, count_d;
    logic       do_pop;
    logic       do_push;
    logic       wr_idx;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        do_pop  = pop_i && (count_q != 2'd0);
        do_push = push_i && ((count_q != 2'd2) || do_pop);
        // Tail index after an optional pop: count - pop, which for the
        // reachable cases (count 0/1 any pop, count 2 with pop) is count[0]^pop.
        wr_idx  = count_q[0] ^ do_pop;

        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            if (do_pop) begin
                slot0_d = slot1_q;
            end
            if (do_push) begin
                if (wr_idx) begin
                    slot1_d = push_data_i;
                end else begin
                    slot0_d = push_data_i;
                end
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign head_o  = slot0_q;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage. Owns the fetch PC, indexes instruction
// memory, and buffers fetched words in a 2-entry FIFO toward decode.
//   clk, rst        clock and synchronous active-high reset
//   imem_addr       word index (fetch_pc - RESET_PC) >> 2, truncated
//   imem_instr      combinational instruction word at imem_addr
//   redirect_valid  load redirect_pc, flush the buffer, resume RUN
//   redirect_pc     byte target; low two bits dropped, flagged if nonzero
//   out_valid       buffer head valid
//   out_ready       decode accepts the head this cycle
//   out_instr       head instruction
//   out_pc, out_pc4 head byte PC and PC + 4
//   misalign_err    sticky, set by a misaligned redirect target
//   halted          fetch is stopped after an ebreak
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter int unsigned IMEM_AW = 20
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_instr,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [31:0]        out_pc,
    output logic [31:0]        out_pc4,
    output logic               misalign_err,
    output logic               halted
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         misalign_q, misalign_d;
    logic [31:0]  pc_off;
    logic         pop;
    logic         push;
    logic [1:0]   buf_count;
    fetch_entry   head;
    fetch_entry   push_data;

    // Targets below RESET_PC or past the memory simply wrap here.
    assign pc_off    = fetch_pc_q - RESET_PC;
    assign imem_addr = IMEM_AW'(pc_off >> 2);

    assign out_valid = (buf_count != 2'd0);
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        misalign_d = misalign_q;
        push       = 1'b0;
        push_data  = '{pc: fetch_pc_q, instr: imem_instr};

        if (redirect_valid) begin
            fetch_pc_d = align_word(redirect_pc);
            state_d    = FS_RUN;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (state_q == FS_RUN && (buf_count != 2'd2 || pop)) begin
            push = 1'b1;
            // ebreak is delivered, but the PC parks on it until a redirect.
            if (imem_instr == INSTR_EBREAK) begin
                state_d = FS_HALT;
            end else begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FS_RUN;
            fetch_pc_q <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            misalign_q <= misalign_d;
        end
    end

    // A pop coinciding with a redirect is discarded by decode; the flush
    // empties the buffer regardless, so the pop is simply gated off.
    fetch_buf2 u_buf (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .pop_i      (pop && !redirect_valid),
        .flush_i    (redirect_valid),
        .push_data_i(push_data),
        .head_o     (head),
        .count_o    (buf_count)
    );

    assign out_instr    = head.instr;
    assign out_pc       = head.pc;
    assign out_pc4      = head.pc + 32'd4;
    assign misalign_err = misalign_q;
    assign halted       = (state_q == FS_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic        misalign_err;
    logic        halted;

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    assign imem_instr = mem[imem_addr[9:0]];

    fetch_unit #(.IMEM_AW(20)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_pc4       (out_pc4),
        .misalign_err  (misalign_err),
        .halted        (halted)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Behavioural model: queue of delivered-but-not-consumed instructions,
    // a program counter, and the halt / misalign flags.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_halt;
    bit          m_mis;

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        logic [31:0] off;
        off = pc - RESET_PC;
        return mem[off[11:2]];
    endfunction

    function automatic logic [31:0] index_of(input logic [31:0] pc);
        logic [31:0] off;
        off = pc - RESET_PC;
        return {12'b0, off[21:2]};
    endfunction

    always @(posedge clk) begin : model
        ent_t e;
        if (rst) begin
            mq.delete();
            m_pc   = RESET_PC;
            m_halt = 0;
            m_mis  = 0;
        end else if (redirect_valid) begin
            mq.delete();
            m_pc   = redirect_pc & 32'hFFFF_FFFC;
            m_halt = 0;
            if (redirect_pc[1:0] != 2'b00) m_mis = 1;
        end else begin
            if (out_ready && mq.size() > 0) void'(mq.pop_front());
            if (!m_halt && mq.size() < 2) begin
                e.pc    = m_pc;
                e.instr = word_at(m_pc);
                mq.push_back(e);
                if (e.instr == INSTR_EBREAK) m_halt = 1;
                else m_pc = m_pc + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
            if (mq.size() != 0) begin
                check("out_instr", out_instr, mq[0].instr);
                check("out_pc", out_pc, mq[0].pc);
                check("out_pc4", out_pc4, mq[0].pc + 32'd4);
            end
            check("imem_addr", {12'b0, imem_addr}, index_of(m_pc));
            check("halted", {31'b0, halted}, {31'b0, m_halt});
            check("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step(1);
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;

        step(1);
        started = 1;
        step(1);
        $display("reset values");
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_pc4", out_pc4, 32'd4);
        check("rst_imem_addr", {12'b0, imem_addr}, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_misalign", {31'b0, misalign_err}, 32'd0);

        // Streaming from reset, one instruction per cycle.
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1);
            $display("stream head %0d pc=%h instr=%h", k, out_pc, out_instr);
            check("stream_valid", {31'b0, out_valid}, 32'd1);
            check("stream_pc", out_pc, 32'h0040_0000 + 4 * k);
            check("stream_instr", out_instr, 32'hA000_0000 + k);
        end

        // Backpressure: buffer fills, PC parks at word 2.
        rst = 1'b1;
        step(1);
        rst       = 1'b0;
        out_ready = 1'b0;
        step(5);
        $display("stall imem_addr=%0d head pc=%h", imem_addr, out_pc);
        check("stall_imem_addr", {12'b0, imem_addr}, 32'd2);
        check("stall_head_pc", out_pc, 32'h0040_0000);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step(1);
            $display("release head pc=%h instr=%h", out_pc, out_instr);
            check("release_pc", out_pc, 32'h0040_0000 + 4 * k);
            check("release_instr", out_instr, 32'hA000_0000 + k);
        end

        // Redirect while full and popping.
        out_ready = 1'b0;
        step(2);
        out_ready = 1'b1;
        redirect_to(32'h0040_0040);
        $display("redirect 0x00400040 out_valid=%0d", out_valid);
        check("redir_bubble", {31'b0, out_valid}, 32'd0);
        check("redir_imem_addr", {12'b0, imem_addr}, 32'd16);
        step(1);
        $display("redirect head pc=%h instr=%h", out_pc, out_instr);
        check("redir_pc", out_pc, 32'h0040_0040);
        check("redir_instr", out_instr, 32'hA000_0010);

        // Misaligned redirect: flag sets and sticks.
        redirect_to(32'h0040_0042);
        $display("misaligned redirect misalign_err=%0d", misalign_err);
        check("mis_flag", {31'b0, misalign_err}, 32'd1);
        step(1);
        check("mis_pc", out_pc, 32'h0040_0040);
        redirect_to(32'h0040_0100);
        check("mis_sticky", {31'b0, misalign_err}, 32'd1);
        step(1);
        $display("aligned redirect head pc=%h misalign_err=%0d", out_pc, misalign_err);
        check("mis_next_pc", out_pc, 32'h0040_0100);

        // ebreak at word 3 halts fetch until a redirect.
        rst    = 1'b1;
        mem[3] = INSTR_EBREAK;
        step(1);
        rst = 1'b0;
        step(3);
        check("pre_ebreak_pc", out_pc, 32'h0040_0008);
        step(1);
        $display("ebreak head pc=%h instr=%h halted=%0d", out_pc, out_instr, halted);
        check("ebreak_instr", out_instr, INSTR_EBREAK);
        check("ebreak_halted", {31'b0, halted}, 32'd1);
        step(2);
        check("halt_empty", {31'b0, out_valid}, 32'd0);
        check("halt_imem_addr", {12'b0, imem_addr}, 32'd3);
        redirect_to(32'h0040_0000);
        check("resume_halted", {31'b0, halted}, 32'd0);
        step(1);
        $display("resume head pc=%h instr=%h", out_pc, out_instr);
        check("resume_pc", out_pc, 32'h0040_0000);
        check("resume_instr", out_instr, 32'hA000_0000);

        // Reset while halted with two entries buffered.
        rst       = 1'b1;
        mem[3]    = 32'hA000_0003;
        mem[1]    = INSTR_EBREAK;
        step(1);
        rst       = 1'b0;
        out_ready = 1'b0;
        step(3);
        check("full_halt", {31'b0, halted}, 32'd1);
        rst = 1'b1;
        step(1);
        $display("reset in halt out_valid=%0d halted=%0d imem_addr=%0d", out_valid, halted, imem_addr);
        check("rsthalt_valid", {31'b0, out_valid}, 32'd0);
        check("rsthalt_halted", {31'b0, halted}, 32'd0);
        check("rsthalt_imem_addr", {12'b0, imem_addr}, 32'd0);
        mem[1] = 32'hA000_0001;
        rst    = 1'b0;

        // Randomized traffic against the model.
        for (int it = 0; it < 3000; it++) begin
            if (it % 500 == 0) begin
                rst = 1'b1;
                for (int i = 0; i < 1024; i++)
                    mem[i] = ($urandom_range(0, 15) == 0) ? INSTR_EBREAK : $urandom;
                step(1);
                rst = 1'b0;
            end
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 7))
                0:       redirect_pc = $urandom;
                1:       redirect_pc = RESET_PC + $urandom_range(0, 4095);
                default: redirect_pc = RESET_PC + 4 * $urandom_range(0, 1023);
            endcase
            step(1);
            $display("rand %0d ready=%0d redir=%0d tgt=%h valid=%0d pc=%h halted=%0d",
                     it, out_ready, redirect_valid, redirect_pc, out_valid, out_pc, halted);
        end
        redirect_valid = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the RV32I core, directly upstream of the instruction memory. Owns the program counter, drives the word index into instruction memory, and captures the returned instruction into a 2-entry fetch buffer with a valid/ready handshake toward decode. Supports redirects from branch/jump resolution, which flush the buffer. Fetch halts on `ebreak` until the next redirect.

## Interface
- `RESET_PC`, 32'h0040_0000, byte address of the first fetch; also the base subtracted to form the memory index.
- `IMEM_AW`, 20, width of the instruction-memory word index.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `imem_addr`  out  IMEM_AW  word index: `(fetch_pc - RESET_PC) >> 2`, truncated to IMEM_AW bits.
- `imem_instr`  in  32  instruction word at `imem_addr`; combinational, valid in the same cycle.
- `redirect_valid`  in  1  load a new PC and flush the buffer.
- `redirect_pc`  in  32  byte target address.
- `out_valid`  out  1  buffer head is valid.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_instr`  out  32  head instruction.
- `out_pc`  out  32  head byte PC.
- `out_pc4`  out  32  `out_pc + 4`, mod 2^32.
- `misalign_err`  out  1  sticky flag: a redirect target had `[1:0] != 0`.
- `halted`  out  1  high while in state HALT.

## Operation
- State register with two states: RUN and HALT.
- Transfer: when `out_valid && out_ready`, the head pops.
- Push condition in RUN: `!redirect_valid && (count < 2 || pop)`. A push writes `{fetch_pc, imem_instr}` and sets `fetch_pc <= fetch_pc + 4`.
- `count` ranges 0..2. When full with a simultaneous pop and push, `count` stays 2 and order is preserved.
- `ebreak` (32'h0010_0073) is pushed normally. On that push, `fetch_pc` holds and the state goes RUN→HALT. In HALT, nothing is pushed.
- Redirect (highest priority, any state):
  - Flush the buffer (`count <= 0`).
  - Load `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
  - Go to RUN.
  - Set `misalign_err` if `redirect_pc[1:0] != 0`.
  - A pop in the same cycle is void: decode must discard it, because the redirect source kills that slot.
- A target below `RESET_PC`, or beyond 2^IMEM_AW words, wraps through the subtraction and truncation. No error is raised.
- `fetch_pc` wraps modulo 2^32.
- `misalign_err` clears only on `rst`.

## Timing
- Reset values:
  - `fetch_pc = RESET_PC`, so `imem_addr = 0`.
  - `count = 0`, `out_valid = 0`, `out_instr = 0`, `out_pc = 0`.
  - `out_pc4 = 4` (always `out_pc + 4`).
  - `misalign_err = 0`, `halted = 0`, state RUN.
- `rst` asserted mid-operation discards the buffer contents and HALT state at the next edge.
- Latency: 1 cycle. The instruction at `imem_addr` in cycle N is at the head in cycle N+1 if the buffer was empty.
- Throughput: 1 instruction/cycle with `out_ready` held high.
- The first `out_valid` appears 1 cycle after `rst` deasserts.
- Redirect at cycle N:
  - `out_valid = 0` at N+1.
  - The target is fetched at N+1 and appears at N+2.
- `out_*` are registered buffer outputs with no combinational path from `out_ready`.
- `imem_addr` depends only on `fetch_pc`.

## Structure
- Shared package `rv32i_pkg`:
  - `RESET_PC`
  - `INSTR_EBREAK = 32'h0010_0073`
  - the fetch-state enum (`FS_RUN`, `FS_HALT`)
  - the `fetch_entry` struct `{pc[31:0], instr[31:0]}`
- One natural sub-module: `fetch_buf2`, a 2-entry FIFO with push, pop, flush and count, holding `fetch_entry`. Flush beats push.
- The PC register, next-PC mux and state machine stay in `fetch_unit`.

## Test plan
- Reset release with memory words 0..3 = A0..A3 and `out_ready = 1` → heads A0..A3 on consecutive cycles starting 1 cycle after reset; `out_pc` = 0x00400000, 0x00400004, 0x00400008, 0x0040000C.
- `out_ready = 0` for 5 cycles after reset:
  - `count` saturates at 2 and `imem_addr` holds at 2.
  - On release, heads arrive in order with no loss or duplication.
- Redirect to 0x00400040 while full and popping in the same cycle → `out_valid = 0` for one cycle, then the head is word 16 with `out_pc = 0x00400040`.
- Redirect to 0x00400042 → `misalign_err = 1`, fetch from 0x00400040; the flag stays set across later redirects until `rst`.
- `ebreak` at word 3:
  - it is delivered with `halted = 1` from the next cycle and no further heads appear;
  - a redirect to 0x00400000 resumes from word 0.
- `rst` asserted with 2 entries buffered in HALT → next cycle `out_valid = 0`, `halted = 0`, `imem_addr = 0`.
